// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO read port, the UART transmitter and the TX pin.
// The transmitter takes the slave view; whatever feeds it takes the master view.
interface fifo_uart_tx_if;
    logic       tx_en;
    logic       fifo_empty;
    logic       fifo_rd;
    logic [7:0] fifo_data;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport slave (
        input  tx_en,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output tx,
        output busy,
        output frame_done
    );

    modport master (
        output tx_en,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  tx,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a registered-output FIFO and serialises each one as UART 8N1.
// Every output, the line included, is registered and changes on the same edge as the state.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.slave  bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             tx_q;
    logic             rd_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_end;

    assign bit_end        = (bit_cnt == CNT_LAST);
    assign bus.tx         = tx_q;
    assign bus.fifo_rd    = rd_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tx_q      <= 1'b1;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (bus.tx_en && !bus.fifo_empty) begin
                        rd_q   <= 1'b1;
                        busy_q <= 1'b1;
                        state  <= POP;
                    end
                end

                // The FIFO samples rd at the end of POP, so its data_out is valid through WAIT.
                POP: begin
                    state <= WAIT;
                end

                WAIT: begin
                    shift_reg <= bus.fifo_data;
                    bit_cnt   <= '0;
                    tx_q      <= 1'b0;
                    state     <= START;
                end

                START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        tx_q    <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                // shift_reg[0] is always the bit on the line; the next one waits in [1].
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            tx_q      <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a registered-output FIFO model feeds the DUT and a UART
// monitor decodes the line against a scoreboard of the bytes loaded into the FIFO.
module tb_fifo_uart_tx;

    localparam int C = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_uart_tx_if bus();

    fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int rd_count    = 0;
    int rd_consec   = 0;
    int fd_count    = 0;
    int overlap     = 0;
    int pop_empty   = 0;

    // FIFO model: data_out and empty are registered, so a push is visible one edge later.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.fifo_rd === 1'b1) begin
                if (fifo_q.size() == 0) pop_empty++;
                else bus.fifo_data <= fifo_q.pop_front();
            end
            bus.fifo_empty <= (fifo_q.size() == 0);
        end
    end

    initial begin
        logic prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.fifo_rd === 1'b1) rd_count++;
            if (bus.fifo_rd === 1'b1 && prev_rd) rd_consec++;
            if (bus.frame_done === 1'b1) fd_count++;
            if (bus.frame_done === 1'b1 && bus.fifo_rd === 1'b1) overlap++;
            prev_rd = (bus.fifo_rd === 1'b1);
        end
    end

    // UART monitor: samples each bit in its middle, starting from the first low cycle.
    initial begin
        bit         mact;
        bit         start_bad;
        int         mpos;
        int         k;
        logic [7:0] mbyte;
        logic [7:0] exp;
        mact = 1'b0;
        start_bad = 1'b0;
        mpos = 0;
        mbyte = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mact = 1'b0;
            end else if (!mact) begin
                if (bus.tx === 1'b0) begin
                    mact = 1'b1;
                    mpos = 0;
                    start_bad = 1'b0;
                end
            end else begin
                mpos++;
                if (mpos >= C/2 && ((mpos - C/2) % C) == 0) begin
                    k = (mpos - C/2) / C;
                    if (k == 0) begin
                        if (bus.tx !== 1'b0) start_bad = 1'b1;
                    end else if (k <= 8) begin
                        mbyte[k-1] = bus.tx;
                    end else begin
                        mact = 1'b0;
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL uart_frame: got unexpected byte %02h, required no frame", mbyte);
                        end else begin
                            exp = exp_q.pop_front();
                            if (mbyte !== exp || bus.tx !== 1'b1 || start_bad) begin
                                miscompares++;
                                $display("FAIL uart_frame: got byte %02h stop %b start_bad %0d, required byte %02h stop 1 start_bad 0",
                                         mbyte, bus.tx, start_bad, exp);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_fd(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fd_count >= target) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.tx_en = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.tx !== 1'b1) begin
            miscompares++; $display("FAIL reset_tx: got %b, required 1", bus.tx);
        end
        vectors++;
        if (bus.fifo_rd !== 1'b0) begin
            miscompares++; $display("FAIL reset_fifo_rd: got %b, required 0", bus.fifo_rd);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
        end
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++; $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame;
        int         rd0, fd0, n;
        logic [9:0] frame;
        rd0 = rd_count;
        fd0 = fd_count;
        frame = {1'b1, 8'hA5, 1'b0};
        bus.tx_en = 1'b1;
        fifo_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                n = i;
                break;
            end
        end
        // one edge for the FIFO's empty register, one to pop, two more to the start bit
        vectors++;
        if (n != 4) begin
            miscompares++; $display("FAIL start_latency: got %0d cycles, required 4", n);
        end
        for (int k = 0; k < 10*C; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (bus.tx !== frame[k/C]) begin
                miscompares++;
                $display("FAIL tx_level cycle %0d: got %b, required %b", k, bus.tx, frame[k/C]);
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end: got frame_done %b busy %b, required 1 0", bus.frame_done, bus.busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.frame_done !== 1'b0) begin
            miscompares++; $display("FAIL frame_done_width: got %b, required 0", bus.frame_done);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (rd_count - rd0 != 1 || fd_count - fd0 != 1) begin
            miscompares++;
            $display("FAIL single_counts: got rd %0d done %0d, required 1 1", rd_count - rd0, fd_count - fd0);
        end
    endtask

    task automatic test_back_to_back;
        int   rd0, fd0, t, nf;
        int   fall[2];
        logic prev_tx;
        bit   ok;
        rd0 = rd_count;
        fd0 = fd_count;
        nf = 0;
        fall[0] = 0;
        fall[1] = 0;
        prev_tx = 1'b1;
        ok = 1'b0;
        fifo_q.push_back(8'h00); exp_q.push_back(8'h00);
        fifo_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (prev_tx === 1'b1 && bus.tx === 1'b0 && nf < 2) begin
                fall[nf] = t;
                nf++;
            end
            prev_tx = bus.tx;
            if (fd_count >= fd0 + 2) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL b2b_timeout: got %0d frames, required 2", fd_count - fd0);
        end
        vectors++;
        if (nf != 2 || fall[1] - fall[0] - 9*C != C + 3) begin
            miscompares++;
            $display("FAIL b2b_stop_gap: got %0d cycles (%0d starts), required %0d", fall[1] - fall[0] - 9*C, nf, C + 3);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (rd_count - rd0 != 2) begin
            miscompares++; $display("FAIL b2b_pops: got %0d, required 2", rd_count - rd0);
        end
        vectors++;
        if (bus.fifo_empty !== 1'b1) begin
            miscompares++; $display("FAIL b2b_empty: got %b, required 1", bus.fifo_empty);
        end
    endtask

    task automatic test_empty_idle;
        int bad, rd0;
        bad = 0;
        rd0 = rd_count;
        bus.tx_en = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if ({bus.fifo_rd, bus.tx, bus.busy} !== 3'b010) bad++;
        end
        vectors++;
        if (bad != 0 || rd_count != rd0) begin
            miscompares++;
            $display("FAIL empty_idle: got %0d bad cycles %0d pops, required 0 0", bad, rd_count - rd0);
        end
    endtask

    task automatic test_tx_en_gate;
        int rd0, fd0;
        bit ok, seen;
        bus.tx_en = 1'b0;
        @(negedge clk);
        rd0 = rd_count;
        fd0 = fd_count;
        fifo_q.push_back(8'h11); exp_q.push_back(8'h11);
        fifo_q.push_back(8'h22); exp_q.push_back(8'h22);
        fifo_q.push_back(8'h33); exp_q.push_back(8'h33);
        repeat (50) @(negedge clk);
        vectors++;
        if (rd_count != rd0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_hold: got %0d pops busy %b, required 0 0", rd_count - rd0, bus.busy);
        end
        bus.tx_en = 1'b1;
        wait_fd(fd0 + 1, 20*C + 50, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL gate_frame1: got %0d frames, required 1", fd_count - fd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL gate_frame2_start: got no start bit, required one");
        end
        repeat (10) @(negedge clk);
        bus.tx_en = 1'b0;
        wait_fd(fd0 + 2, 20*C + 50, ok);
        repeat (100) @(negedge clk);
        vectors++;
        if (!ok || fd_count - fd0 != 2 || rd_count - rd0 != 2 || fifo_q.size() != 1) begin
            miscompares++;
            $display("FAIL gate_drop: got frames %0d pops %0d left %0d, required 2 2 1",
                     fd_count - fd0, rd_count - rd0, fifo_q.size());
        end
        bus.tx_en = 1'b1;
        wait_fd(fd0 + 3, 20*C + 50, ok);
        repeat (3) @(negedge clk);
        vectors++;
        if (!ok || rd_count - rd0 != 3) begin
            miscompares++; $display("FAIL gate_resume: got %0d pops, required 3", rd_count - rd0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int         rd0, fd0;
        bit         seen, ok;
        logic [7:0] dropped;
        bus.tx_en = 1'b1;
        rd0 = rd_count;
        fd0 = fd_count;
        fifo_q.push_back(8'h3C); exp_q.push_back(8'h3C);
        fifo_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (4*C + 1) @(negedge clk);
        vectors++;
        if (!seen || bus.tx !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_bit3: got tx %b busy %b started %0d, required 1 1 1", bus.tx, bus.busy, seen);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_rd !== 1'b0 || bus.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got tx %b busy %b rd %b done %b, required 1 0 0 0",
                     bus.tx, bus.busy, bus.fifo_rd, bus.frame_done);
        end
        dropped = exp_q.pop_front();
        @(negedge clk);
        rst = 1'b1;
        wait_fd(fd0 + 1, 20*C + 50, ok);
        repeat (3) @(negedge clk);
        vectors++;
        if (!ok || fd_count - fd0 != 1 || rd_count - rd0 != 2 || fifo_q.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_recover: got frames %0d pops %0d left %0d (dropped %02h), required 1 2 0",
                     fd_count - fd0, rd_count - rd0, fifo_q.size(), dropped);
        end
    endtask

    task automatic test_fill31;
        int rd0, fd0;
        bit ok;
        bus.tx_en = 1'b1;
        rd0 = rd_count;
        fd0 = fd_count;
        for (int b = 0; b < 31; b++) begin
            fifo_q.push_back(8'(b));
            exp_q.push_back(8'(b));
        end
        wait_fd(fd0 + 31, 31*(10*C + 10) + 100, ok);
        repeat (10) @(negedge clk);
        vectors++;
        if (!ok || rd_count - rd0 != 31) begin
            miscompares++;
            $display("FAIL fill31_pops: got %0d pops %0d frames, required 31 31", rd_count - rd0, fd_count - fd0);
        end
        vectors++;
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL fill31_drain: got fifo %0d pending %0d, required 0 0", fifo_q.size(), exp_q.size());
        end
    endtask

    task automatic test_protocol;
        vectors++;
        if (pop_empty != 0) begin
            miscompares++; $display("FAIL pop_while_empty: got %0d, required 0", pop_empty);
        end
        vectors++;
        if (rd_consec != 0) begin
            miscompares++; $display("FAIL rd_consecutive: got %0d, required 0", rd_consec);
        end
        vectors++;
        if (overlap != 0) begin
            miscompares++; $display("FAIL rd_done_overlap: got %0d, required 0", overlap);
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.tx_en = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_empty_idle();
        test_tx_en_gate();
        test_reset_mid_frame();
        test_fill31();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
